// File: rtl/lut_cfg_pkg.sv
// Shared types and helpers for the serial LUT configuration loader.
// Optional even-parity framing is enabled by defining LUT_CFG_PARITY_EN.
package lut_cfg_pkg;
  localparam int LUT_BITS = 16;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, DONE} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/lut_config_loader_if.sv
// Configuration-controller side of the LUT loader: start/abort control,
// bit-serial valid/ready stream and status flags.
interface lut_config_loader_if;
  logic cfg_start;
  logic cfg_abort;
  logic cfg_bit;
  logic cfg_bit_valid;
  logic cfg_bit_ready;
  logic cfg_busy;
  logic cfg_done;
  logic cfg_error;

  modport master (
    output cfg_start, cfg_abort, cfg_bit, cfg_bit_valid,
    input  cfg_bit_ready, cfg_busy, cfg_done, cfg_error
  );

  modport slave (
    input  cfg_start, cfg_abort, cfg_bit, cfg_bit_valid,
    output cfg_bit_ready, cfg_busy, cfg_done, cfg_error
  );
endinterface

// File: rtl/lut_cfg_shifter.sv
// Shadow register and bit/LUT position counters for one configuration frame.
// With LUT_CFG_PARITY_EN each LUT is followed by an even-parity bit that is checked, not stored.
module lut_cfg_shifter
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         accept,
  input  logic                         bit_in,
  output logic [NUM_LUTS*LUT_BITS-1:0] shadow,
  output logic                         last_bit
`ifdef LUT_CFG_PARITY_EN
  , output logic                       parity_err
`endif
);
  localparam int BCW = clog2(LUT_BITS);
  localparam int LCW = (NUM_LUTS > 1) ? clog2(NUM_LUTS) : 1;

  logic [BCW-1:0]     bit_cnt;
  logic [LCW-1:0]     lut_cnt;
  logic [LCW+BCW-1:0] idx;
  logic               last_lut;
  logic               last_data;

  assign idx       = {lut_cnt, bit_cnt};
  assign last_lut  = (lut_cnt == LCW'(NUM_LUTS - 1));
  assign last_data = (bit_cnt == BCW'(LUT_BITS - 1));

`ifdef LUT_CFG_PARITY_EN
  logic par_phase;
  logic par_acc;

  // The frame ends on the parity bit of the last LUT, not on its last data bit.
  assign last_bit   = par_phase && last_lut;
  assign parity_err = par_phase && (par_acc ^ bit_in);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shadow    <= '0;
      bit_cnt   <= '0;
      lut_cnt   <= '0;
      par_phase <= 1'b0;
      par_acc   <= 1'b0;
    end else if (accept) begin
      if (par_phase) begin
        par_phase <= 1'b0;
        par_acc   <= 1'b0;
        lut_cnt   <= lut_cnt + 1'b1;
      end else begin
        shadow[idx] <= bit_in;
        par_acc     <= par_acc ^ bit_in;
        bit_cnt     <= bit_cnt + 1'b1;
        if (last_data) par_phase <= 1'b1;
      end
    end
  end
`else
  assign last_bit = last_data && last_lut;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      shadow  <= '0;
      bit_cnt <= '0;
      lut_cnt <= '0;
    end else if (accept) begin
      shadow[idx] <= bit_in;
      bit_cnt     <= bit_cnt + 1'b1;
      if (last_data) lut_cnt <= lut_cnt + 1'b1;
    end
  end
`endif
endmodule

// File: rtl/lut_config_loader.sv
// Serial LUT truth-table loader: FSM, handshake and atomic commit of the shadow frame.
// Define LUT_CFG_PARITY_EN for per-LUT even-parity checking with sticky cfg_error.
module lut_config_loader
  import lut_cfg_pkg::*;
#(
  parameter int NUM_LUTS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  lut_config_loader_if.slave           cfg,
  output logic [NUM_LUTS*LUT_BITS-1:0] lut_cfg,
  output logic                         lut_cfg_valid
);
  state_t                       state, state_nxt;
  logic                         accept;
  logic                         clear;
  logic                         last_bit;
  logic [NUM_LUTS*LUT_BITS-1:0] shadow;

  // A bit offered alongside an abort is dropped.
  assign accept            = (state == SHIFT) && cfg.cfg_bit_valid && !cfg.cfg_abort;
  assign cfg.cfg_bit_ready = (state == SHIFT);
  assign cfg.cfg_busy      = (state != IDLE);
  assign cfg.cfg_done      = (state == DONE);

`ifdef LUT_CFG_PARITY_EN
  logic parity_err;
  logic err;

  lut_cfg_shifter #(.NUM_LUTS(NUM_LUTS)) u_shifter (
    .clk, .rst_n, .clear, .accept, .bit_in(cfg.cfg_bit),
    .shadow, .last_bit, .parity_err
  );

  always_ff @(posedge clk) begin
    if (!rst_n || clear) err <= 1'b0;
    else if (accept && parity_err) err <= 1'b1;
  end

  assign cfg.cfg_error = err;
`else
  lut_cfg_shifter #(.NUM_LUTS(NUM_LUTS)) u_shifter (
    .clk, .rst_n, .clear, .accept, .bit_in(cfg.cfg_bit),
    .shadow, .last_bit
  );

  assign cfg.cfg_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    clear     = 1'b0;
    case (state)
      IDLE: begin
        if (cfg.cfg_start && !cfg.cfg_abort) begin
          state_nxt = SHIFT;
          clear     = 1'b1;
        end
      end
      SHIFT: begin
        if (cfg.cfg_abort) begin
          state_nxt = IDLE;
        end else if (accept) begin
`ifdef LUT_CFG_PARITY_EN
          if (parity_err) state_nxt = IDLE;
          else
`endif
          if (last_bit) state_nxt = COMMIT;
        end
      end
      COMMIT:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lut_cfg       <= '0;
      lut_cfg_valid <= 1'b0;
    end else if (state == COMMIT) begin
      lut_cfg       <= shadow;
      lut_cfg_valid <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lut_config_loader.sv
// Randomized self-checking bench for lut_config_loader (NUM_LUTS=4);
// also covers the LUT_CFG_PARITY_EN build when that macro is defined.
module tb_lut_config_loader;
  localparam int NL = 4;
  localparam int LB = 16;
  localparam int FW = NL * LB;
`ifdef LUT_CFG_PARITY_EN
  localparam int PB = LB + 1;
`else
  localparam int PB = LB;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [FW-1:0] lut_cfg;
  logic          lut_cfg_valid;

  lut_config_loader_if cfg_if ();

  lut_config_loader #(.NUM_LUTS(NL)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cfg           (cfg_if.slave),
    .lut_cfg       (lut_cfg),
    .lut_cfg_valid (lut_cfg_valid)
  );

  always #5 clk = ~clk;

  logic [FW-1:0] exp_cfg;
  logic          exp_valid;
  int            n_tests;
  int            n_fail;
  bit            bq[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Serialise a frame: LUT 0 first, LSB first, optional even-parity bit per LUT.
  task automatic build(input logic [FW-1:0] data, input int bad_lut);
    bq.delete();
    for (int k = 0; k < NL; k++) begin
      for (int b = 0; b < LB; b++) bq.push_back(data[k*LB+b]);
`ifdef LUT_CFG_PARITY_EN
      begin
        bit p;
        p = ^data[k*LB +: LB];
        if (k == bad_lut) p = ~p;
        bq.push_back(p);
      end
`else
      if (k == bad_lut) bq.push_back(1'b0);
`endif
    end
  endtask

  task automatic start_load();
    cfg_if.cfg_start = 1'b1;
    step();
    cfg_if.cfg_start = 1'b0;
    chk("busy_after_start", 64'(cfg_if.cfg_busy), 64'd1);
  endtask

  // mode 0: valid every cycle, 1: toggling, 2: random, 3: random with stray starts
  task automatic stream(input int nbits, input int mode);
    int  n;
    int  cyc;
    bit  v;
    n   = 0;
    cyc = 0;
    while (n < nbits && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      cfg_if.cfg_start     = (mode == 3) && (cyc % 7 == 3);
      cfg_if.cfg_bit_valid = v;
      cfg_if.cfg_bit       = v ? bq[n] : 1'($urandom);
      chk("ready_in_shift", 64'(cfg_if.cfg_bit_ready), 64'd1);
      if (v && cfg_if.cfg_bit_ready) n++;
      step();
      cyc++;
    end
    cfg_if.cfg_bit_valid = 1'b0;
    cfg_if.cfg_start     = 1'b0;
    chk("stream_count", 64'(n), 64'(nbits));
  endtask

  // Called right after the last bit's edge: COMMIT cycle, then DONE, then IDLE.
  task automatic finish_commit(input logic [FW-1:0] data, input bit start_in_done);
    chk("commit_no_partial", lut_cfg, exp_cfg);
    chk("commit_done_low", 64'(cfg_if.cfg_done), 64'd0);
    step();
    exp_cfg   = data;
    exp_valid = 1'b1;
    chk("lut_cfg", lut_cfg, exp_cfg);
    chk("lut_cfg_valid", 64'(lut_cfg_valid), 64'(exp_valid));
    chk("done_pulse", 64'(cfg_if.cfg_done), 64'd1);
    cfg_if.cfg_start = start_in_done;
    step();
    cfg_if.cfg_start = 1'b0;
    chk("done_cleared", 64'(cfg_if.cfg_done), 64'd0);
    chk("idle_busy", 64'(cfg_if.cfg_busy), 64'd0);
    step();
    chk("single_done", 64'(cfg_if.cfg_done), 64'd0);
    chk("start_in_done_ignored", 64'(cfg_if.cfg_busy), 64'd0);
  endtask

  task automatic full_load(input logic [FW-1:0] data, input int mode, input bit start_in_done);
    build(data, -1);
    start_load();
    stream(bq.size(), mode);
    finish_commit(data, start_in_done);
  endtask

  initial begin
    logic [FW-1:0] d;
    n_tests = 0;
    n_fail  = 0;
    exp_cfg   = '0;
    exp_valid = 1'b0;
    cfg_if.cfg_start     = 1'b0;
    cfg_if.cfg_abort     = 1'b0;
    cfg_if.cfg_bit       = 1'b0;
    cfg_if.cfg_bit_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    chk("rst_ready", 64'(cfg_if.cfg_bit_ready), 64'd0);
    chk("rst_busy", 64'(cfg_if.cfg_busy), 64'd0);
    chk("rst_done", 64'(cfg_if.cfg_done), 64'd0);
    chk("rst_error", 64'(cfg_if.cfg_error), 64'd0);
    chk("rst_lut_cfg", lut_cfg, 64'd0);
    chk("rst_valid", 64'(lut_cfg_valid), 64'd0);

    // Abort after 20 bits; the bit offered with the abort must not land.
    build({FW{1'b1}}, -1);
    start_load();
    stream(20, 0);
    cfg_if.cfg_abort     = 1'b1;
    cfg_if.cfg_bit_valid = 1'b1;
    cfg_if.cfg_bit       = 1'b1;
    step();
    cfg_if.cfg_abort     = 1'b0;
    cfg_if.cfg_bit_valid = 1'b0;
    chk("abort_busy", 64'(cfg_if.cfg_busy), 64'd0);
    chk("abort_lut_cfg", lut_cfg, 64'd0);
    chk("abort_valid", 64'(lut_cfg_valid), 64'd0);
    step();
    chk("abort_no_done", 64'(cfg_if.cfg_done), 64'd0);

    full_load({FW{1'b1}}, 0, 1'b0);
    full_load(64'hFFFF_8000_0001_A5A5, 0, 1'b0);
    full_load(64'hFFFF_8000_0001_A5A5, 1, 1'b0);
    full_load({$urandom, $urandom}, 3, 1'b1);

    // Abort and start together in IDLE: abort wins.
    cfg_if.cfg_start = 1'b1;
    cfg_if.cfg_abort = 1'b1;
    step();
    cfg_if.cfg_start = 1'b0;
    cfg_if.cfg_abort = 1'b0;
    chk("abort_wins_busy", 64'(cfg_if.cfg_busy), 64'd0);
    chk("abort_wins_ready", 64'(cfg_if.cfg_bit_ready), 64'd0);

    for (int i = 0; i < 6; i++) full_load({$urandom, $urandom}, 2, 1'b0);

    // Reset asserted while bit 40 is offered.
    build({$urandom, $urandom}, -1);
    start_load();
    stream(40, 0);
    rst_n = 1'b0;
    cfg_if.cfg_bit_valid = 1'b1;
    step();
    exp_cfg   = '0;
    exp_valid = 1'b0;
    chk("midrst_lut_cfg", lut_cfg, exp_cfg);
    chk("midrst_valid", 64'(lut_cfg_valid), 64'(exp_valid));
    chk("midrst_busy", 64'(cfg_if.cfg_busy), 64'd0);
    chk("midrst_ready", 64'(cfg_if.cfg_bit_ready), 64'd0);
    rst_n = 1'b1;
    cfg_if.cfg_bit_valid = 1'b0;
    step();
    chk("midrst_idle", 64'(cfg_if.cfg_busy), 64'd0);

    full_load({$urandom, $urandom}, 2, 1'b0);

`ifdef LUT_CFG_PARITY_EN
    d = {$urandom, $urandom};
    build(d, 1);
    start_load();
    stream(2 * PB, 0);
    chk("par_error", 64'(cfg_if.cfg_error), 64'd1);
    chk("par_busy", 64'(cfg_if.cfg_busy), 64'd0);
    chk("par_no_done", 64'(cfg_if.cfg_done), 64'd0);
    chk("par_lut_cfg_kept", lut_cfg, exp_cfg);
    step();
    chk("par_error_sticky", 64'(cfg_if.cfg_error), 64'd1);
    chk("par_no_done2", 64'(cfg_if.cfg_done), 64'd0);
    build(d, -1);
    start_load();
    chk("par_error_cleared", 64'(cfg_if.cfg_error), 64'd0);
    stream(bq.size(), 2);
    finish_commit(d, 1'b0);
`else
    d = {$urandom, $urandom};
    full_load(d, 1, 1'b0);
    chk("error_tied_low", 64'(cfg_if.cfg_error), 64'd0);
`endif

    chk("frame_len", 64'(bq.size()), 64'(NL * PB));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
